// File: rtl/memory_responder_pkg.sv
// Shared definitions for the CPU memory interface and the memory responder.
// Holds the CPU opcode encodings, the memory-interface widths and the
// responder FSM state type.
package memory_responder_pkg;

  // Memory-interface widths; these match the CPU MAR and MBR/AC registers.
  localparam int unsigned MEM_ADDR_W = 11;
  localparam int unsigned MEM_DATA_W = 16;

  // CPU opcodes, load through brz.
  typedef enum logic [3:0] {
    OpLoad  = 4'h0,
    OpStore = 4'h1,
    OpAdd   = 4'h2,
    OpSub   = 4'h3,
    OpAnd   = 4'h4,
    OpOr    = 4'h5,
    OpNot   = 4'h6,
    OpJmp   = 4'h7,
    OpBrz   = 4'h8
  } opcode_e;

  // Responder handshake states.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StDone
  } resp_state_e;

endpackage

// File: rtl/memory_responder_mem_array_1rw.sv
// Synchronous single-port DEPTH x DATA_W memory array.
// Contents have no reset. Reads are registered and return the old word when
// a write hits the same address on the same edge.
// Ports:
//   clock  - system clock
//   we     - write enable
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data for the address presented on the previous edge
module memory_responder_mem_array_1rw #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: word-addressed data memory answering the CPU rd/wr
// interface. One request at a time is captured, WAIT_CYCLES wait states are
// inserted, then a four-phase ready handshake returns the result. Requests
// with an out-of-range address or with rd and wr both high return err=1.
// Ports:
//   clock    - system clock
//   reset_n  - asynchronous active-low reset (memory contents are kept)
//   rd, wr   - request levels, held by the initiator until ready is seen
//   addr     - word address, sampled at request capture
//   wdata    - write data, sampled at request capture
//   rdata    - read data, valid while ready=1 for a read; held afterwards
//   ready    - response valid, held until rd and wr are both low
//   busy     - high from request capture until the return to idle
//   err      - response is an error, valid while ready=1
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  CntLoad  = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

  resp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_rd_q, op_rd_d;
  logic              op_err_q, op_err_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req_err;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign req_err = (rd & wr) | ({1'b0, addr} >= DepthLim);

  // While idle the array is addressed straight from the bus so that, even
  // with zero wait states, the read word is available during the RESP cycle.
  assign mem_addr = (state_q == StIdle) ? addr[AW-1:0] : addr_q;
  assign mem_we   = (state_q == StResp) & ~op_err_q & ~op_rd_q;

  memory_responder_mem_array_1rw #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_rd_d  = op_rd_q;
    op_err_d = op_err_q;
    ready_d  = ready_q;
    err_d    = err_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (rd | wr) begin
          addr_d   = addr[AW-1:0];
          wdata_d  = wdata;
          op_rd_d  = rd;
          op_err_d = req_err;
          cnt_d    = CntLoad;
          state_d  = (WAIT_CYCLES > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StResp;
        end
      end
      StResp: begin
        // The write itself is committed by the array on this same edge.
        ready_d = 1'b1;
        state_d = StDone;
        if (op_err_q) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (op_rd_q) begin
          rdata_d = mem_rdata;
        end
      end
      StDone: begin
        if (!rd && !wr) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_rd_q  <= 1'b0;
      op_err_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_rd_q  <= op_rd_d;
      op_err_q <= op_err_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Word-addressed 16-bit data memory that serves as the responder side of the CPU's rd/wr memory interface.
- Accepts one read or write request at a time. Inserts a programmable number of wait states, then answers with a four-phase ready handshake.
- Flags illegal requests: out-of-range address, or rd and wr asserted together.
- Sits between the CPU's MAR/MBR datapath and the memory array. Replaces the CPU-internal array in the next integration step.

Parameters:
- DEPTH, 64, number of 16-bit words implemented (addresses 0..DEPTH-1).
- ADDR_W, 11, address width; matches the CPU MAR width.
- DATA_W, 16, data word width; matches the CPU MBR/AC width.
- WAIT_CYCLES, 1, extra wait states between request capture and response (0 is legal).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rd  input  1  read request from the initiator; level, held until ready is seen.
- wr  input  1  write request from the initiator; level, held until ready is seen.
- addr  input  ADDR_W  word address; sampled at request capture.
- wdata  input  DATA_W  write data; sampled at request capture.
- rdata  output  DATA_W  read data; valid while ready=1 for a read.
- ready  output  1  response valid; held until rd and wr are both low.
- busy  output  1  high from request capture until return to IDLE.
- err  output  1  response is an error; valid while ready=1.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: state=IDLE, ready=0, busy=0, err=0, rdata=0, wait counter=0.
  - Memory array contents are NOT cleared. A write not yet committed when reset asserts is discarded.
- FSM states: IDLE, WAIT, RESP, DONE.
- IDLE:
  - On a rising edge with rd|wr=1, latch addr, wdata and the operation. Set busy=1.
  - Load the counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - Decrement the counter each edge.
  - When the counter equals 1 on an edge, go to RESP.
  - rd/wr/addr changes are ignored (captured values are used).
- RESP (entry edge):
  - Legal write: commit memory[addr] <= wdata; rdata unchanged.
  - Legal read: rdata <= memory[addr].
  - Error (addr >= DEPTH, or rd&wr=1 at capture): no memory update, rdata <= 0, err <= 1.
  - ready <= 1. Next state DONE.
- DONE:
  - ready, err and rdata hold.
  - When rd=0 and wr=0 on an edge: ready<=0, err<=0, busy<=0, go to IDLE.
  - rdata keeps its last value after leaving DONE.
- Latency: request sampled at edge E; ready rises at edge E+WAIT_CYCLES+1.
- Minimum spacing between requests: one idle edge after the initiator drops rd/wr.
- Read-after-write to the same address returns the newly written data.
- Address width: addr is compared as unsigned against DEPTH. No wrap-around; out of range is an error.
- Counter width is clog2(WAIT_CYCLES+1), minimum 1 bit.
- Request dropped early (rd/wr low before ready): the transaction still completes. ready pulses high for exactly one cycle, then IDLE.
- Flags (ZF/CF/OF/NF) are not produced here; they remain CPU-side.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants load..brz.
  - Memory-interface constants MEM_ADDR_W=11, MEM_DATA_W=16.
  - Responder state enum {IDLE, WAIT, RESP, DONE}.
- One natural sub-module: mem_array_1rw. Synchronous single-port DEPTHxDATA_W array (we, addr, wdata, rdata) with no reset on contents. The responder FSM wraps it.

Test Plan:
- Write then read, WAIT_CYCLES=1: wr addr=20 wdata=16'h0002, then rd addr=20 -> ready at capture+2 edges, rdata=16'h0002, err=0.
- Zero wait states, WAIT_CYCLES=0: rd addr=25 after writing 16'hFFFB -> ready exactly one edge after capture, rdata=16'hFFFB.
- Out-of-range: wr addr=64 wdata=16'h1234 -> ready=1, err=1, rdata=0. A following rd addr=0 returns its prior value, unchanged.
- Illegal rd&wr=1 at addr=5 -> ready=1, err=1, memory[5] unchanged.
- Four-phase hold: keep rd high 5 cycles after ready -> ready/rdata stay asserted. Drop rd -> ready=0, busy=0 on the next edge; a new request is accepted after one idle edge.
- Reset mid-operation: assert reset_n=0 during WAIT of wr addr=7 wdata=16'hABCD -> ready=busy=err=0 immediately; later rd addr=7 returns the old value, not 16'hABCD.
